// File: rtl/tpg_pkg.sv
// Shared types and constants for the video test-pattern generator.
//   tpg_mode_e : pattern selector encoding (matches the mode_sel port)
//   rgb_t      : 24-bit pixel colour payload
//   BAR_LUT    : eight colour-bar entries, left to right
//   BOX_COLOR  : overlay colour of the optional moving box
package tpg_pkg;

  typedef enum logic [1:0] {
    TPG_BARS   = 2'd0,
    TPG_CHECK  = 2'd1,
    TPG_SCROLL = 2'd2,
    TPG_GRAD   = 2'd3
  } tpg_mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t BOX_COLOR = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

  // red, green, blue, white, yellow, cyan, magenta, orange
  localparam rgb_t BAR_LUT [8] = '{
    '{r: 8'hFF, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'hFF},
    '{r: 8'hFF, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'h80, b: 8'h00}
  };

endpackage

// File: rtl/tpg_bounce_box.sv
// Moving box overlay: position/direction registers that bounce between the
// screen edges once per frame, plus a combinational hit test for the pixel.
// Ports:
//   clk, rst_n     : pixel clock, async active-low reset
//   fs             : one-cycle frame-start strobe
//   freeze         : hold position and direction
//   x, y           : current pixel coordinate
//   hit_c          : pixel lies inside the box (combinational)
module tpg_bounce_box
  import tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned BOX_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fs,
  input  logic               freeze,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit_c
);

  localparam int unsigned X_LIMIT = H_ACTIVE - BOX_SIZE;
  localparam int unsigned Y_LIMIT = V_ACTIVE - BOX_SIZE;
  localparam int unsigned EXT_W   = COORD_W + 1;

  logic [COORD_W-1:0] box_x_q, box_y_q, box_x_d, box_y_d;
  // direction bit: 0 = increasing, 1 = decreasing
  logic               dir_x_q, dir_y_q, dir_x_d, dir_y_d;

  // One step per unfrozen frame; at an edge the step reverses instead.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (fs && !freeze) begin
      if (!dir_x_q) begin
        if (32'(box_x_q) >= X_LIMIT) begin
          dir_x_d = 1'b1;
          box_x_d = box_x_q - COORD_W'(1);
        end else begin
          box_x_d = box_x_q + COORD_W'(1);
        end
      end else begin
        if (box_x_q == '0) begin
          dir_x_d = 1'b0;
          box_x_d = box_x_q + COORD_W'(1);
        end else begin
          box_x_d = box_x_q - COORD_W'(1);
        end
      end
      if (!dir_y_q) begin
        if (32'(box_y_q) >= Y_LIMIT) begin
          dir_y_d = 1'b1;
          box_y_d = box_y_q - COORD_W'(1);
        end else begin
          box_y_d = box_y_q + COORD_W'(1);
        end
      end else begin
        if (box_y_q == '0) begin
          dir_y_d = 1'b0;
          box_y_d = box_y_q + COORD_W'(1);
        end else begin
          box_y_d = box_y_q - COORD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  // Upper bound compared one bit wider so box_x + BOX_SIZE cannot wrap.
  always_comb begin
    hit_c = (x >= box_x_q) &&
            (EXT_W'(x) < (EXT_W'(box_x_q) + EXT_W'(BOX_SIZE))) &&
            (y >= box_y_q) &&
            (EXT_W'(y) < (EXT_W'(box_y_q) + EXT_W'(BOX_SIZE)));
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Registered video test-pattern generator (bars, checker, scrolling
// checker, gradient) with one cycle of latency on colour and sync.
// Optional moving-box overlay built when TPG_MOVING_BOX_EN is defined.
// Ports:
//   clk, rst_n                     : pixel clock, async active-low reset
//   x, y                           : pixel coordinate
//   vde, hsync_in, vsync_in        : timing from the pixel timing generator
//   mode_sel                       : pattern request, taken at frame start
//   freeze                         : hold animation state
//   red, green, blue               : registered pixel colour
//   vde_out, hsync_out, vsync_out  : timing delayed by one cycle
//   frame_cnt                      : frames since reset, wraps at 256
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned BAR_COUNT   = 8,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned SCROLL_STEP = 1,
  parameter int unsigned BOX_SIZE    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               vde,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode_sel,
  input  logic               freeze,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               vde_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned BAR_W    = H_ACTIVE / BAR_COUNT;
  localparam int unsigned BAR_LAST = BAR_COUNT - 1;

  // Elaboration-time parameter sanity checks.
  if ((H_ACTIVE % BAR_COUNT) != 0) begin : g_bad_bars
    $error("H_ACTIVE must be divisible by BAR_COUNT");
  end
  if (CHECK_LOG2 >= COORD_W) begin : g_bad_check
    $error("CHECK_LOG2 must index a bit of the coordinate");
  end
  if ((BOX_SIZE == 0) || (BOX_SIZE > H_ACTIVE) || (BOX_SIZE > V_ACTIVE)) begin : g_bad_box
    $error("BOX_SIZE must be non-zero and fit inside the active area");
  end

  logic               vsync_q;
  logic               fs_c;
  tpg_mode_e          mode_q;
  logic [COORD_W-1:0] offset_q;

  assign fs_c = vsync_in & ~vsync_q;

  // Frame-rate state: mode, frame counter and scroll offset change only on fs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      mode_q    <= TPG_BARS;
      frame_cnt <= 8'd0;
      offset_q  <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (fs_c) begin
        mode_q    <= tpg_mode_e'(mode_sel);
        frame_cnt <= frame_cnt + 8'd1;
        if (!freeze) begin
          offset_q <= offset_q + COORD_W'(SCROLL_STEP);
        end
      end
    end
  end

  logic [COORD_W-1:0] bar_idx_c;
  logic [2:0]         lut_sel_c;
  logic [COORD_W-1:0] xs_c;
  logic               chk_c;
  logic               chk_s_c;
  rgb_t               pat_c;
  rgb_t               pix_c;

  // Pattern selection from the current-cycle coordinate and the held mode.
  always_comb begin
    bar_idx_c = x / COORD_W'(BAR_W);
    lut_sel_c = (32'(bar_idx_c) > BAR_LAST) ? 3'(BAR_LAST) : 3'(bar_idx_c);
    xs_c      = x + offset_q;
    chk_c     = 1'((x ^ y) >> CHECK_LOG2);
    chk_s_c   = 1'((xs_c ^ y) >> CHECK_LOG2);
    pat_c     = RGB_BLACK;
    case (mode_q)
      TPG_BARS:   pat_c = BAR_LUT[lut_sel_c];
      TPG_CHECK:  pat_c = chk_c ? RGB_WHITE : RGB_BLACK;
      TPG_SCROLL: pat_c = chk_s_c ? RGB_WHITE : RGB_BLACK;
      TPG_GRAD:   pat_c = '{r: 8'(x), g: 8'(y), b: frame_cnt};
      default:    pat_c = RGB_BLACK;
    endcase
  end

`ifdef TPG_MOVING_BOX_EN
  logic box_hit_c;

  tpg_bounce_box #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COORD_W  (COORD_W),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk    (clk),
    .rst_n  (rst_n),
    .fs     (fs_c),
    .freeze (freeze),
    .x      (x),
    .y      (y),
    .hit_c  (box_hit_c)
  );

  assign pix_c = box_hit_c ? BOX_COLOR : pat_c;
`else
  assign pix_c = pat_c;
`endif

  // Output stage: colour blanked outside active video, timing delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red       <= 8'd0;
      green     <= 8'd0;
      blue      <= 8'd0;
      vde_out   <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      vde_out   <= vde;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      if (vde) begin
        red   <= pix_c.r;
        green <= pix_c.g;
        blue  <= pix_c.b;
      end else begin
        red   <= 8'd0;
        green <= 8'd0;
        blue  <= 8'd0;
      end
    end
  end

endmodule
